// File: rtl/busmux_pkg.sv
// Shared types and constants for the round-robin bus arbiter mux.
// Optional burst ownership is enabled by defining BUSMUX_LOCK_EN.
package busmux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first requesting channel at or after ptr, wrapping modulo CHANNELS.
// Purely combinational; any=0 gives idx=0 and an all-zero one-hot.
module rr_pick
  import busmux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = clog2(DEF_CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                any,
  output logic [SEL_W-1:0]    idx,
  output logic [CHANNELS-1:0] onehot
);

  int         j;
  logic [SEL_W-1:0] sel;

  always_comb begin
    any    = |req;
    idx    = '0;
    onehot = '0;
    j      = 0;
    sel    = '0;
    // Scan from farthest to nearest offset so the nearest requester wins last.
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= CHANNELS) j = j - CHANNELS;
      sel = SEL_W'(j);
      if (req[sel]) idx = sel;
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_bus_arbiter_mux.sv
// N-channel registered bus mux with round-robin arbitration and valid/ready output.
// Define BUSMUX_LOCK_EN to add a lock input that freezes the priority pointer on capture.
module rr_bus_arbiter_mux
  import busmux_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
`ifdef BUSMUX_LOCK_EN
  input  logic                      lock,
`endif
  output logic [CHANNELS-1:0]       grant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_idx
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] idx_q;
  logic             any;
  logic [SEL_W-1:0] win_idx;
  logic [CHANNELS-1:0] win_onehot;
  logic             capture;
  logic             hold_ptr;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (any),
    .idx    (win_idx),
    .onehot (win_onehot)
  );

`ifdef BUSMUX_LOCK_EN
  assign hold_ptr = lock;
`else
  assign hold_ptr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    capture = 1'b0;
    // A held word may be replaced in the same cycle it is accepted.
    if ((state_q == IDLE) || out_ready) begin
      capture = any;
      state_d = any ? HOLD : IDLE;
    end
    if (capture && !hold_ptr) begin
      ptr_d = (int'(win_idx) == CHANNELS - 1) ? '0 : win_idx + 1'b1;
    end
    grant = capture ? win_onehot : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (capture) begin
        data_q <= data_in[int'(win_idx)*WIDTH +: WIDTH];
        idx_q  <= win_idx;
      end
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_idx   = idx_q;

endmodule

// File: tb/tb_rr_bus_arbiter_mux.sv
// Randomised and directed bench for rr_bus_arbiter_mux against a behavioural model.
// Builds with or without BUSMUX_LOCK_EN.
module tb_rr_bus_arbiter_mux;

  localparam int W = 8;
  localparam int C = 4;
`ifdef BUSMUX_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [C-1:0] req;
  logic [C*W-1:0] data_in;
  logic         lock;
  logic [C-1:0] grant;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_idx;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  bit m_valid;
  int m_data;
  int m_idx;
  int m_ptr;
  logic [C-1:0] g_seen;

  always #5 clk = ~clk;

  rr_bus_arbiter_mux #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
`ifdef BUSMUX_LOCK_EN
    .lock      (lock),
`endif
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [C-1:0] r, input int p);
    for (int k = 0; k < C; k++) begin
      if (r[(p + k) % C]) return (p + k) % C;
    end
    return -1;
  endfunction

  function automatic logic [C*W-1:0] put(input int ch, input logic [W-1:0] v,
                                         input logic [C*W-1:0] base);
    logic [C*W-1:0] t;
    t = base;
    t[ch*W +: W] = v;
    return t;
  endfunction

  // One cycle: drive, check every output against the model, advance the model.
  task automatic step(input logic [C-1:0] r, input logic [C*W-1:0] d,
                      input bit rdy, input bit lk);
    int  w;
    bit  cap;
    int  exp_g;
    @(negedge clk);
    req = r; data_in = d; out_ready = rdy; lock = lk;
    #1;
    w     = pick(r, m_ptr);
    cap   = (!m_valid || rdy) && (w >= 0);
    exp_g = cap ? (1 << w) : 0;
    g_seen = grant;
    chk("grant", int'(grant), exp_g);
    chk("out_valid", int'(out_valid), int'(m_valid));
    if (m_valid) begin
      chk("out_data", int'(out_data), m_data);
      chk("out_idx", int'(out_idx), m_idx);
    end
    if (cap) begin
      m_valid = 1'b1;
      m_data  = int'(d[w*W +: W]);
      m_idx   = w;
      if (!(LOCK_EN && lk)) m_ptr = (w + 1) % C;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = 0; m_idx = 0; m_ptr = 0;
  endtask

  initial begin
    logic [C*W-1:0] d;
    logic [W-1:0]   held;
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};
    req = '0; data_in = '0; out_ready = 1'b0; lock = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_grant", int'(grant), 0);
    rst_n = 1'b1;

    // capture A5 on channel 0, then reset while it is still held
    step(4'b0001, put(0, 8'hA5, '0), 1'b1, 1'b0);
    chk("a5_data", int'(out_data), 'hA5);
    @(negedge clk);
    req = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(out_data), 0);
    chk("midrst_idx", int'(out_idx), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // fairness from reset pointer
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, $urandom, 1'b1, 1'b0);
      chk("fair_idx", int'(out_idx), exp_seq[i]);
      chk("fair_valid", int'(out_valid), 1);
    end
    step('0, $urandom, 1'b1, 1'b0);
    chk("idle_valid", int'(out_valid), 0);

    // single requester on channel 2
    step(4'b0100, put(2, 8'h3C, 32'h11223344), 1'b1, 1'b0);
    chk("single_grant", int'(g_seen), 4'b0100);
    chk("single_data", int'(out_data), 'h3C);
    chk("single_idx", int'(out_idx), 2);

    // pointer now 3: channel 0 wins by wrap-around, then drain
    step(4'b0001, put(0, 8'h5A, '0), 1'b1, 1'b0);
    chk("wrap_idx", int'(out_idx), 0);
    step('0, $urandom, 1'b1, 1'b0);
    chk("empty_valid", int'(out_valid), 0);
    chk("empty_data", int'(out_data), 'h5A);

    // pointer 1: winner 1, then backpressure for five cycles
    step(4'b1111, $urandom, 1'b1, 1'b0);
    chk("bp_first_idx", int'(out_idx), 1);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      step(C'($urandom), $urandom, 1'b0, 1'b0);
      chk("bp_grant", int'(g_seen), 0);
      chk("bp_data", int'(out_data), int'(held));
    end
    step(4'b1111, $urandom, 1'b1, 1'b0);
    chk("bp_next_grant", int'(g_seen), 4'b0100);
    chk("bp_next_idx", int'(out_idx), 2);
    step('0, $urandom, 1'b1, 1'b0);

`ifdef BUSMUX_LOCK_EN
    // pointer 3; drop 1000 once to land the pointer on 0
    step(4'b1000, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, $urandom, 1'b1, 1'b1);
      chk("lock_idx", int'(out_idx), 0);
    end
    step(4'b0011, $urandom, 1'b1, 1'b0);
    chk("unlock_idx0", int'(out_idx), 0);
    step(4'b0011, $urandom, 1'b1, 1'b0);
    chk("unlock_idx1", int'(out_idx), 1);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      d = {$urandom};
      step(($urandom_range(0, 3) == 0) ? '0 : C'($urandom), d,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
